// File: rtl/updown_ctrl_pkg.sv
// rtl/updown_ctrl_pkg.sv - shared types and defaults for the up/down counter front-end control
package updown_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } ctrl_state_t;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int DIV_DEF        = 50;
  localparam int CLR_PULSE_DEF  = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus stability counter for one raw push-button
module btn_debounce
  import updown_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic Clear,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int             CW   = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!Clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_ctrl.sv
// rtl/updown_counter_ctrl.sv - run/clear FSM, tick prescaler and direction control feeding the 4-bit counter
module updown_counter_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIV        = DIV_DEF,
  parameter int CLR_PULSE  = CLR_PULSE_DEF
) (
  input  logic CLK,
  input  logic Clear,
  input  logic BtnRun,
  input  logic BtnDir,
  input  logic BtnClr,
  output logic CntTick,
  output logic UD,
  output logic CntClearN,
  output logic Running
);

  localparam int             PW    = cnt_width(DIV);
  localparam logic [PW-1:0]  DLAST = PW'(DIV - 1);
  localparam int             CPW   = cnt_width(CLR_PULSE);
  localparam logic [CPW-1:0] CLAST = CPW'(CLR_PULSE - 1);

  logic [2:0]     unused_levels;
  logic           run_press;
  logic           dir_press;
  logic           clr_press;

  ctrl_state_t    state;
  ctrl_state_t    state_nx;
  logic           stay_run;
  logic           dir_req;
  logic           toggle;
  logic           pend;
  logic [PW-1:0]  psc;
  logic [CPW-1:0] pcnt;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .CLK   (CLK),
    .Clear (Clear),
    .raw   (BtnRun),
    .level (unused_levels[0]),
    .press (run_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
    .CLK   (CLK),
    .Clear (Clear),
    .raw   (BtnDir),
    .level (unused_levels[1]),
    .press (dir_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .CLK   (CLK),
    .Clear (Clear),
    .raw   (BtnClr),
    .level (unused_levels[2]),
    .press (clr_press)
  );

  always_ff @(posedge CLK) begin
    if (!Clear) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (clr_press)      state_nx = ST_CLEAR;
        else if (run_press) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (clr_press)      state_nx = ST_CLEAR;
        else if (run_press) state_nx = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_press)          state_nx = ST_CLEAR;
        else if (pcnt == CLAST) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    Running  = (state == ST_RUN);
    stay_run = (state == ST_RUN) && (state_nx == ST_RUN);
    dir_req  = dir_press && (state != ST_CLEAR);
    toggle   = pend ^ dir_req;
  end

  always_ff @(posedge CLK) begin
    if (!Clear) begin
      psc       <= '0;
      CntTick   <= 1'b0;
      pcnt      <= '0;
      CntClearN <= 1'b0;
      UD        <= 1'b0;
      pend      <= 1'b0;
    end else begin
      CntClearN <= (state_nx != ST_CLEAR);

      if (stay_run) begin
        if (psc == DLAST) begin
          psc     <= '0;
          CntTick <= 1'b1;
        end else begin
          psc     <= psc + 1'b1;
          CntTick <= 1'b0;
        end
      end else begin
        psc     <= '0;
        CntTick <= 1'b0;
      end

      // Entry into ST_CLEAR, or a fresh clear press inside it, restarts the low phase
      if ((state == ST_CLEAR) && (state_nx == ST_CLEAR) && !clr_press) begin
        pcnt <= pcnt + 1'b1;
      end else begin
        pcnt <= '0;
      end

      // UD may only move on an edge where CntTick is low, so the counter's
      // falling-edge sample never sees a direction change
      if (clr_press) begin
        pend <= 1'b0;
        if (dir_req && !CntTick) UD <= ~UD;
      end else if (CntTick) begin
        pend <= toggle;
      end else begin
        pend <= 1'b0;
        UD   <= UD ^ toggle;
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// tb/tb_updown_counter_ctrl.sv - scoreboard bench for updown_counter_ctrl with directed button stimulus
module tb_updown_counter_ctrl;

  localparam logic [4:0] M5  = 5'b11111;
  localparam logic [4:0] M4  = 5'b01111;
  localparam logic [4:0] M_L = 5'b10000;
  localparam logic [4:0] M_R = 5'b01000;
  localparam logic [4:0] M_T = 5'b00100;
  localparam logic [4:0] M_U = 5'b00010;
  localparam logic [4:0] M_C = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] mask;
    logic [4:0] val;
    string      tag;
  } exp_t;

  logic CLK;
  logic Clear;
  logic BtnRun;
  logic BtnDir;
  logic BtnClr;
  logic CntTick;
  logic UD;
  logic CntClearN;
  logic Running;
  logic unused_l_tick;
  logic unused_l_ud;
  logic l_clrn;
  logic unused_l_running;

  exp_t sbq[$];
  int   cyc       = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   tick_cnt  = 0;
  int   fall_viol = 0;
  logic prev_tick = 1'b0;
  logic prev_ud   = 1'b0;

  updown_counter_ctrl #(.DEB_CYCLES(4), .DIV(5), .CLR_PULSE(3)) dut (
    .CLK       (CLK),
    .Clear     (Clear),
    .BtnRun    (BtnRun),
    .BtnDir    (BtnDir),
    .BtnClr    (BtnClr),
    .CntTick   (CntTick),
    .UD        (UD),
    .CntClearN (CntClearN),
    .Running   (Running)
  );

  // Long clear pulse makes a re-press inside ST_CLEAR reachable through the debouncer
  updown_counter_ctrl #(.DEB_CYCLES(4), .DIV(5), .CLR_PULSE(16)) dut_long (
    .CLK       (CLK),
    .Clear     (Clear),
    .BtnRun    (BtnRun),
    .BtnDir    (BtnDir),
    .BtnClr    (BtnClr),
    .CntTick   (unused_l_tick),
    .UD        (unused_l_ud),
    .CntClearN (l_clrn),
    .Running   (unused_l_running)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push_exp(input int off, input logic [4:0] m, input logic [4:0] v, input string t);
    exp_t e;
    int   i;
    e.cyc  = cyc + off;
    e.mask = m;
    e.val  = v;
    e.tag  = t;
    i = 0;
    while (i < sbq.size() && sbq[i].cyc <= e.cyc) i++;
    sbq.insert(i, e);
  endtask

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic run_for(input int n);
    logic [4:0] obs;
    exp_t       e;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
      cyc++;
      obs = {l_clrn, Running, CntTick, UD, CntClearN};
      if (CntTick === 1'b1) tick_cnt++;
      if (prev_tick && (CntTick === 1'b0) && (UD !== prev_ud)) fall_viol++;
      prev_tick = (CntTick === 1'b1);
      prev_ud   = UD;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        checks++;
        assert ((obs & e.mask) === (e.val & e.mask)) else begin
          errors++;
          $error("FAIL %s @%0d: observed=%b expected=%b mask=%b", e.tag, cyc, obs, e.val, e.mask);
        end
      end
    end
  endtask

  initial begin
    Clear  = 1'b0;
    BtnRun = 1'b0;
    BtnDir = 1'b0;
    BtnClr = 1'b0;

    // Reset held three edges, then released
    push_exp(1, M5, 5'b00000, "rst_1");
    push_exp(2, M5, 5'b00000, "rst_2");
    push_exp(3, M5, 5'b00000, "rst_3");
    run_for(3);
    Clear = 1'b1;
    push_exp(1, M5, 5'b10001, "rst_release");
    push_exp(4, M5, 5'b10001, "idle_after_rst");
    run_for(5);
    check("no_tick_after_rst", tick_cnt, 0);

    // Run press, ticks every 5th cycle, second run press lands on a tick edge
    BtnRun = 1'b1;
    push_exp(6,  M_R,       5'b00000, "run_not_yet");
    push_exp(7,  M_R | M_T, 5'b01000, "run_entered");
    push_exp(11, M_T,       5'b00000, "tick_pre");
    push_exp(12, M4,        5'b01101, "tick_first");
    push_exp(13, M_T,       5'b00000, "tick_one_cycle");
    push_exp(17, M_T,       5'b00100, "tick_second");
    push_exp(22, M_T,       5'b00100, "tick_third");
    run_for(20);
    BtnRun = 1'b0;
    push_exp(7,  M_T, 5'b00100, "tick_fourth");
    push_exp(12, M_T, 5'b00100, "tick_fifth");
    run_for(15);
    BtnRun = 1'b1;
    push_exp(2,  M_T, 5'b00100, "tick_sixth");
    push_exp(6,  M4,  5'b01001, "stop_pre");
    push_exp(7,  M4,  5'b00001, "stop_on_tick_edge");
    push_exp(12, M4,  5'b00001, "stopped");
    run_for(10);
    BtnRun = 1'b0;
    run_for(10);
    check("ticks_first_run", tick_cnt, 6);

    // Bouncy direction button, then stable high
    BtnDir = 1'b1; run_for(1);
    BtnDir = 1'b0; run_for(1);
    BtnDir = 1'b1; run_for(1);
    BtnDir = 1'b0; run_for(1);
    BtnDir = 1'b1;
    push_exp(2,  M_U, 5'b00000, "dir_bounce_quiet");
    push_exp(6,  M4,  5'b00001, "dir_pre_toggle");
    push_exp(7,  M4,  5'b00011, "dir_toggled");
    push_exp(20, M4,  5'b00011, "dir_single_toggle");
    run_for(10);
    BtnDir = 1'b0;
    run_for(12);

    // Dir press landing in a tick cycle waits one extra cycle
    BtnRun = 1'b1;
    push_exp(7,  M4, 5'b01011, "run2_entered");
    push_exp(12, M4, 5'b01111, "run2_tick1");
    push_exp(17, M4, 5'b01111, "run2_tick_dir");
    push_exp(18, M4, 5'b01011, "ud_held_on_fall");
    push_exp(19, M4, 5'b01001, "ud_pending_applied");
    push_exp(22, M4, 5'b01101, "run2_tick3");
    run_for(8);
    BtnRun = 1'b0;
    run_for(3);
    BtnDir = 1'b1;
    run_for(8);
    BtnDir = 1'b0;
    run_for(6);

    // Clear press while running
    BtnClr = 1'b1;
    push_exp(2,  M_T, 5'b00100, "run2_tick4");
    push_exp(6,  M4,  5'b01001, "clr_pre");
    push_exp(7,  M4,  5'b00000, "clr_low_1");
    push_exp(7,  M_L, 5'b00000, "long_clr_low_1");
    push_exp(8,  M4,  5'b00000, "clr_low_2");
    push_exp(9,  M4,  5'b00000, "clr_low_3");
    push_exp(10, M4,  5'b00001, "clr_done");
    push_exp(10, M_L, 5'b00000, "long_clr_still_low");
    push_exp(12, M4,  5'b00001, "clr_idle");
    run_for(7);
    BtnClr = 1'b0;
    run_for(13);

    // Run and clear presses in the same cycle
    BtnRun = 1'b1;
    BtnClr = 1'b1;
    push_exp(6,  M4, 5'b00001, "both_pre");
    push_exp(7,  M4, 5'b00000, "both_clear_wins");
    push_exp(8,  M4, 5'b00000, "both_low_2");
    push_exp(9,  M4, 5'b00000, "both_low_3");
    push_exp(10, M4, 5'b00001, "both_idle");
    push_exp(16, M4, 5'b00001, "both_no_run");
    run_for(8);
    BtnRun = 1'b0;
    BtnClr = 1'b0;
    run_for(12);
    check("ticks_total", tick_cnt, 10);

    // Mid-operation reset, then clear re-pressed inside ST_CLEAR
    Clear = 1'b0;
    push_exp(1, M5, 5'b00000, "rst2_1");
    push_exp(2, M5, 5'b00000, "rst2_2");
    run_for(2);
    Clear = 1'b1;
    push_exp(1, M5, 5'b10001, "rst2_release");
    run_for(1);
    BtnClr = 1'b1;
    push_exp(6,  M5,  5'b10001, "re_pre");
    push_exp(7,  M5,  5'b00000, "re_low");
    push_exp(10, M_C, 5'b00001, "re_main_first_done");
    push_exp(19, M_C, 5'b00000, "re_main_second_low");
    push_exp(21, M_C, 5'b00000, "re_main_second_low3");
    push_exp(22, M_C, 5'b00001, "re_main_second_done");
    push_exp(23, M_L, 5'b00000, "re_long_extended");
    push_exp(34, M_L, 5'b00000, "re_long_last_low");
    push_exp(35, M_L, 5'b10000, "re_long_done");
    run_for(7);
    BtnClr = 1'b0;
    run_for(5);
    BtnClr = 1'b1;
    run_for(8);
    BtnClr = 1'b0;
    run_for(20);

    check("scoreboard_drained", sbq.size(), 0);
    check("ud_never_on_tick_fall", fall_viol, 0);
    check("no_tick_after_clear", tick_cnt, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
